svi_rr_scheduler: RTL
=====================

# svi_rr_scheduler

- Round-robin scheduler that shares one downstream consumer between `SIZE` requesters.
- Requesters are the elements of an SVI array; each presents a request bit and a two-bit scalar payload (`a`, `b`).
- Grants one requester at a time and holds its captured payload stable until the consumer accepts it over a valid/ready handshake.
- Sits in `top` between the per-element generate loop and the registered `o_a`/`o_b` outputs, replacing the unarbitrated many-to-one collapse.

## Interface

Parameters:
- `SIZE`, default 8: number of requesters; legal range 2..64.
- `IDX_W`, derived as `$clog2(SIZE)`: index width; not overridden.

Ports:
- `i_clk`  input  1: single clock; all state updates on its rising edge.
- `i_rst`  input  1: reset, synchronous, active-high.
- `i_req`  input  SIZE: per-requester request.
- `i_mask`  input  SIZE: 1 = requester disabled, not eligible.
- `i_a`  input  SIZE: per-requester payload bit `a`.
- `i_b`  input  SIZE: per-requester payload bit `b`.
- `i_ready`  input  1: consumer accepts the current transfer.
- `o_valid`  output  1: captured payload valid.
- `o_a`  output  1: captured `a` of the granted requester.
- `o_b`  output  1: captured `b` of the granted requester.
- `o_idx`  output  IDX_W: index of the granted requester.
- `o_gnt`  output  SIZE: one-hot grant; all zero when idle.
- `o_xfer_cnt`  output  16: completed-handshake counter; wraps.

## Operation

- Registered state: FSM state (`IDLE`, `BUSY`), round-robin pointer `ptr` (IDX_W bits), captured payload and index, grant vector, transfer counter.
- Eligibility: `elig = i_req & ~i_mask`.
- Handshake: `o_valid & i_ready`.
  - In the handshake cycle, the currently granted index is removed from `elig`.
  - A requester therefore cannot win twice in consecutive cycles.
- Selection: the first set bit of `elig` scanning upward from `ptr`, wrapping from `SIZE-1` to 0.
- Loading a grant:
  - Capture `i_a[k]`, `i_b[k]` and `k` into the output registers.
  - Set `o_gnt` to one-hot `k` and assert `o_valid`.
  - Update `ptr <= (k == SIZE-1) ? 0 : k+1`.
- `IDLE`:
  - `elig != 0`: load a grant and go to `BUSY`.
  - Otherwise stay in `IDLE` with all outputs except `o_xfer_cnt` at 0.
- `BUSY`, no handshake: hold all outputs and `ptr` unchanged.
  - Changes on `i_a`, `i_b`, `i_req` or `i_mask` have no effect on the held outputs.
  - Masking or dropping the granted requester does not revoke its grant.
- `BUSY`, handshake:
  - Increment `o_xfer_cnt` modulo 2^16.
  - If the reduced `elig` is nonzero, load the next grant in the same edge (back-to-back, no bubble).
  - Otherwise clear `o_valid`, `o_gnt`, `o_a`, `o_b`, `o_idx` and go to `IDLE`.
- `i_ready` while `o_valid` = 0 is ignored.
- Reset, taking priority at any point including mid-`BUSY`: state `IDLE`, `ptr` = 0, all outputs = 0, `o_xfer_cnt` = 0.

## Timing

- Request-to-valid latency: 1 cycle.
  - A request sampled in `IDLE` at edge N gives `o_valid` = 1 after edge N.
- Next-grant latency: 0 bubbles when another eligible requester exists at the handshake edge.
- A lone streaming requester sees 1 idle cycle between its grants.
- Peak throughput: 1 transfer per cycle with ≥ 2 eligible requesters.
- Fairness: every continuously eligible, unmasked requester is granted within `SIZE` handshakes.
- Outputs are purely registered; there is no combinational path from inputs to outputs.
- `o_xfer_cnt` updates on the handshake edge; wrap from 16'hFFFF to 0 is silent.

## Test plan

All scenarios use `SIZE` = 8.

- Reset: hold `i_rst` = 1 with `i_req` = 8'hFF for 3 cycles.
  - Required: `o_valid`, `o_gnt`, `o_idx`, `o_a`, `o_b`, `o_xfer_cnt` all 0.
  - Required: first grant after release is index 0.
- Two-requester alternation: `i_req` = 8'b0000_0101, `i_ready` = 1 continuously.
  - Required: `o_idx` sequence 0, 2, 0, 2 with `o_valid` held at 1.
  - Required: `o_xfer_cnt` increments every cycle.
- Backpressure: grant index 3 with `i_a[3]` = 1, then hold `i_ready` = 0 for 4 cycles while toggling `i_a[3]` and dropping `i_req[3]`.
  - Required: `o_a` = 1, `o_idx` = 3, `o_gnt` = 8'h08 stable throughout; `o_xfer_cnt` unchanged.
- Masking: `i_req` = 8'hFF, `i_mask` = 8'hF0, `i_ready` = 1.
  - Required: `o_idx` sequence 0, 1, 2, 3, 0; indices 4–7 never granted.
- Single requester: `i_req` = 8'h80, `i_ready` = 1.
  - Required: `o_valid` pattern 1, 0, 1, 0 with `o_idx` = 7 on every valid cycle.
- Reset mid-transfer: assert `i_rst` for 1 cycle while `BUSY` with `o_xfer_cnt` = 5 and `ptr` = 4.
  - Required: next cycle all outputs 0 and `o_xfer_cnt` = 0.
  - Required: with `i_req` = 8'h30, the next grant is index 4.

Source files
------------

// File: rtl/svi_rr_scheduler.sv
// Round-robin scheduler that shares one valid/ready consumer between SIZE
// requesters. The winner's payload is captured and held until it is accepted.
module svi_rr_scheduler #(
  parameter int SIZE  = 8,
  parameter int IDX_W = $clog2(SIZE)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [SIZE-1:0]   i_req,
  input  logic [SIZE-1:0]   i_mask,
  input  logic [SIZE-1:0]   i_a,
  input  logic [SIZE-1:0]   i_b,
  input  logic              i_ready,
  output logic              o_valid,
  output logic              o_a,
  output logic              o_b,
  output logic [IDX_W-1:0]  o_idx,
  output logic [SIZE-1:0]   o_gnt,
  output logic [15:0]       o_xfer_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [IDX_W:0]   SIZE_X = (IDX_W+1)'(SIZE);
  localparam logic [IDX_W-1:0] LAST   = IDX_W'(SIZE - 1);

  state_t           state;
  state_t           state_next;
  logic [IDX_W-1:0] ptr;
  logic             hs;
  logic [SIZE-1:0]  elig;
  logic [IDX_W:0]   cand;
  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;
  logic [IDX_W-1:0] ptr_next;
  logic [SIZE-1:0]  gnt_next;
  logic             load_grant;
  logic             clear_out;

  assign hs = o_valid & i_ready;

  // The requester being accepted this cycle may not win again on the same edge.
  assign elig = i_req & ~i_mask & ~(hs ? o_gnt : '0);

  // Scan from the highest offset down so the last hit is the one closest to ptr.
  always_comb begin
    cand      = '0;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = SIZE - 1; i >= 0; i--) begin
      cand = {1'b0, ptr} + (IDX_W+1)'(i);
      if (cand >= SIZE_X) begin
        cand = cand - SIZE_X;
      end
      if (elig[cand[IDX_W-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    gnt_next          = '0;
    gnt_next[sel_idx] = 1'b1;
    ptr_next          = (sel_idx == LAST) ? '0 : sel_idx + IDX_W'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load_grant = 1'b0;
    clear_out  = 1'b0;
    case (state)
      IDLE: begin
        if (sel_found) begin
          load_grant = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (hs) begin
          if (sel_found) begin
            load_grant = 1'b1;
          end else begin
            clear_out  = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output registers only change on a new grant or when the last transfer drains.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ptr        <= '0;
      o_valid    <= 1'b0;
      o_a        <= 1'b0;
      o_b        <= 1'b0;
      o_idx      <= '0;
      o_gnt      <= '0;
      o_xfer_cnt <= '0;
    end else begin
      if (hs) begin
        o_xfer_cnt <= o_xfer_cnt + 16'd1;
      end
      if (load_grant) begin
        ptr     <= ptr_next;
        o_valid <= 1'b1;
        o_a     <= i_a[sel_idx];
        o_b     <= i_b[sel_idx];
        o_idx   <= sel_idx;
        o_gnt   <= gnt_next;
      end else if (clear_out) begin
        o_valid <= 1'b0;
        o_a     <= 1'b0;
        o_b     <= 1'b0;
        o_idx   <= '0;
        o_gnt   <= '0;
      end
    end
  end

endmodule
